// File: rtl/instr_fetch.sv
// Instruction fetch controller: one outstanding read at pc, holds the returned word
// for the decoder, and is the sole driver of the PC register's enable/mode.
module instr_fetch #(
   parameter  int unsigned MaxOutstanding = 1,
   localparam int unsigned WordW          = 32
) (
   input  logic             clk_i,
   input  logic             res_i,
   input  logic [WordW-1:0] pc_i,
   output logic             pc_enable_o,
   output logic             pc_mode_o,
   input  logic             jump_i,
   output logic             mem_req_o,
   output logic [WordW-1:0] mem_addr_o,
   input  logic             mem_gnt_i,
   input  logic             mem_rvalid_i,
   input  logic [WordW-1:0] mem_rdata_i,
   output logic [WordW-1:0] instr_o,
   output logic [WordW-1:0] instr_pc_o,
   output logic             instr_valid_o,
   input  logic             instr_ready_i
);

   localparam logic PcModeIncrement = 1'b0;
   localparam logic PcModeJump      = 1'b1;

   if (MaxOutstanding != 1) begin : g_bad_cfg
      $error("instr_fetch: only MaxOutstanding == 1 is supported");
   end

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2,
      StHold = 2'd3
   } state_e;

   state_e           state_q;
   logic             discard_q;
   logic             mem_req_q;
   logic             instr_valid_q;
   logic [WordW-1:0] pend_addr_q;
   logic [WordW-1:0] instr_q;
   logic [WordW-1:0] instr_pc_q;

   logic             jump_act;
   logic             accept;

   // PC control: a jump always wins over the increment of an accepted fetch
   always_comb begin
      jump_act    = jump_i && (state_q != StIdle);
      accept      = (state_q == StWait) && mem_rvalid_i && !discard_q && !jump_i;
      pc_enable_o = jump_act || accept;
      pc_mode_o   = jump_act ? PcModeJump : PcModeIncrement;
   end

   always_ff @(posedge clk_i) begin
      if (!res_i) begin
         state_q       <= StIdle;
         discard_q     <= 1'b0;
         mem_req_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         pend_addr_q   <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_q   <= StReq;
               mem_req_q <= 1'b1;
            end
            StReq: begin
               if (mem_gnt_i) begin
                  pend_addr_q <= pc_i;
                  discard_q   <= jump_i;
                  state_q     <= StWait;
                  mem_req_q   <= 1'b0;
               end
            end
            StWait: begin
               // Only one read is ever in flight, so any response clears discard
               if (mem_rvalid_i) begin
                  discard_q <= 1'b0;
                  if (accept) begin
                     instr_q       <= mem_rdata_i;
                     instr_pc_q    <= pend_addr_q;
                     instr_valid_q <= 1'b1;
                     state_q       <= StHold;
                  end else begin
                     mem_req_q <= 1'b1;
                     state_q   <= StReq;
                  end
               end else if (jump_i) begin
                  discard_q <= 1'b1;
               end
            end
            StHold: begin
               if (jump_i || instr_ready_i) begin
                  instr_valid_q <= 1'b0;
                  mem_req_q     <= 1'b1;
                  state_q       <= StReq;
               end
            end
         endcase
      end
   end

   assign mem_req_o     = mem_req_q;
   assign mem_addr_o    = mem_req_q ? pc_i : '0;
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;
   assign instr_valid_o = instr_valid_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch controller sitting between the program counter register and the instruction memory port. It consumes the current `pc`, issues a read request with a request/grant handshake, and captures the returned instruction word. It holds that word for the decoder under a valid/ready handshake. It is the only driver of the PC register's `enable` and `mode` inputs, and it discards in-flight fetches when the execute stage signals a taken jump.

## Interface

Parameters:
- `MaxOutstanding`, default 1. Number of in-flight memory reads. Fixed at 1 for this revision; any other value is a elaboration error.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `res`  in  1  synchronous, active-low reset; sampled on rising `clk`. 0 resets, 1 runs.
- `pc`  in  word  current program counter from the PC register.
- `pc_enable`  out  1  enable to the PC register; combinational.
- `pc_mode`  out  1  `PC_MODE_INCREMENT` or `PC_MODE_JUMP` to the PC register; combinational.
- `jump`  in  1  taken jump or branch from execute, single-cycle pulse. The target is on the PC register's `jmp_addr` in the same cycle.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  word  read address; equals `pc` while `mem_req`=1.
- `mem_gnt`  in  1  memory accepted the request this cycle.
- `mem_rvalid`  in  1  read data valid; arrives at least 1 cycle after grant.
- `mem_rdata`  in  word  read data.
- `instr`  out  word  captured instruction.
- `instr_pc`  out  word  address `instr` was fetched from.
- `instr_valid`  out  1  `instr`/`instr_pc` are valid.
- `instr_ready`  in  1  decoder accepts `instr` this cycle.

## Operation

The state machine has four states: IDLE, REQ, WAIT and HOLD. There is also a 1-bit `discard` flag, plus `instr` and `instr_pc` registers.

- **IDLE**
  - Entered on reset.
  - Goes to REQ unconditionally on the next cycle.
  - All outputs are 0.
- **REQ**
  - `mem_req`=1, `mem_addr`=`pc`.
  - On `mem_gnt`: latch `pc` into a pending-address register and go to WAIT.
  - Otherwise stay in REQ.
- **WAIT**
  - `mem_req`=0.
  - On `mem_rvalid` with `discard`=0 (and no `jump`):
    - capture `instr`<=`mem_rdata` and `instr_pc`<=pending address;
    - drive `pc_enable`=1 with `pc_mode`=INCREMENT in this same cycle;
    - go to HOLD.
  - On `mem_rvalid` with `discard`=1: drop the data, clear `discard`, go to REQ. The PC is untouched.
- **HOLD**
  - `instr_valid`=1.
  - On `instr_ready`: go to REQ.
  - Otherwise hold `instr` and `instr_pc` stable.

Jump handling (`jump`=1 in any state except IDLE):
- Drive `pc_enable`=1 and `pc_mode`=JUMP that cycle. A jump always beats an increment; there is never a double update.
- **REQ with `mem_gnt`=1:** go to WAIT with `discard`<=1.
- **REQ with `mem_gnt`=0:** stay in REQ. `mem_addr` follows the new `pc` from the next cycle.
- **WAIT without `mem_rvalid`:** `discard`<=1 and stay in WAIT.
- **WAIT with `mem_rvalid`:**
  - if `discard`=0, drop the data and go to REQ;
  - if `discard`=1, drop the data, keep `discard`=1 (now standing for the jump's own flush) and go to REQ.
  - Correction: this revision has only one outstanding read, so in both cases go to REQ with `discard`<=0.
- **HOLD:** deassert `instr_valid` next cycle and go to REQ, even if `instr_ready`=1 that cycle. The jump kills the held instruction.
- **IDLE:** ignore `jump`.

## Timing

- Reset (`res`=0 at a rising edge):
  - state IDLE, `discard`=0;
  - `instr`=0, `instr_pc`=0;
  - outputs `mem_req`=0, `instr_valid`=0, `pc_enable`=0, `pc_mode`=INCREMENT.
- Reset mid-fetch abandons the transaction. A late `mem_rvalid` arriving while in IDLE or REQ is ignored.
- Minimum fetch loop, with grant in the request cycle and rvalid 1 cycle later:
  - REQ (cycle 0);
  - WAIT with rvalid (cycle 1);
  - HOLD with `instr_valid`=1 (cycle 2);
  - if `instr_ready`=1 in cycle 2, REQ again in cycle 3.
  - Throughput is one instruction per 3 cycles.
- The PC increments at the rising edge that ends the rvalid cycle. The `mem_addr` of the next REQ is therefore already `pc`+`INSTRUCTION_SIZE_IN_BYTES`.
- `pc_enable` is high for exactly one cycle per accepted fetch or jump.
- `instr` and `instr_pc` change only on the HOLD entry edge.
- `mem_addr` is stable while `mem_req`=1, except for the cycle after a jump.
- `pc` wraps modulo 2^32 in the PC register; this block performs no arithmetic.

## Test plan

- **Reset and first fetch.** PC with InitAddr=0x0000_0000; memory grants immediately and returns 0x0000_0013 after 1 cycle.
  - Required: `mem_req` first rises 1 cycle after `res` goes high, with `mem_addr`=0x0;
  - `instr`=0x13 and `instr_pc`=0x0 with `instr_valid`;
  - `pc`=0x4 afterwards.
- **Backpressure.** Hold `instr_ready`=0 for 5 cycles.
  - Required: `instr_valid` stays 1 and `instr` is stable;
  - `mem_req`=0 throughout;
  - `pc` is incremented exactly once.
- **Grant stall.** `mem_gnt`=0 for 3 cycles.
  - Required: `mem_req`=1 with constant `mem_addr`=0x4;
  - no `pc_enable` until the rvalid cycle.
- **Jump during WAIT.** `jump` with `jmp_addr`=0x100 one cycle before rvalid.
  - Required: the returned data is discarded and `instr_valid` never rises for it;
  - next `mem_addr`=0x100;
  - the next instruction has `instr_pc`=0x100;
  - `pc` ends at 0x104.
- **Jump coincident with rvalid, and jump during HOLD with `instr_ready`=1.**
  - Required: no increment occurs, `pc`=jump target, the held instruction is not consumed, and the fetch restarts at the target.
- **Reset mid-WAIT, followed by a late `mem_rvalid`.**
  - Required: all outputs return to reset values, the late data is ignored, and the fetch restarts at 0x0.
